// File: rtl/arb_banco_pkg.sv
// Shared types for the round-robin bank write arbiter.
package arb_banco_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, ACK} arb_state_t;

   // Index width; kept at least 1 bit so small N still yields a legal vector.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/arbitro_banco_rr_sel.sv
// Round-robin pick: first set req bit scanning ptr, ptr+1, ... with wrap.
module rr_selector
   import arb_banco_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   int p;

   // Scan from the far end back towards ptr so the closest hit wins;
   // wrap by compare so N need not be a power of 2.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      p     = 0;
      for (int j = N-1; j >= 0; j--) begin
         p = int'(ptr) + j;
         if (p >= N) p = p - N;
         if (req[p]) begin
            valid = 1'b1;
            idx   = IW'(p);
         end
      end
   end

endmodule

// File: rtl/banco_registros.sv
// Shared K-bit state register; captures D on every edge, no enable.
module BancoRegistros #(
   parameter int k = 12
) (
   input  logic         CLK,
   input  logic         Reset,
   input  logic [k-1:0] D,
   output logic [k-1:0] Q
);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) Q <= '0;
      else       Q <= D;
   end

endmodule

// File: rtl/arbitro_banco_rr.sv
// Round-robin write arbiter/sequencer owning the shared register bank.
module arbitro_banco_rr
   import arb_banco_pkg::*;
#(
   parameter int N = 4,
   parameter int K = 12
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic [N-1:0]          req,
   input  logic [N*K-1:0]        wdata,
   output logic [N-1:0]          gnt,
   output logic [N-1:0]          ack,
   output logic [idx_w(N)-1:0]   gnt_idx,
   output logic                  busy,
   output logic [K-1:0]          Q
);

   localparam int IW = idx_w(N);

   arb_state_t    state, state_nxt;
   logic [IW-1:0] ptr, ptr_nxt, idx_nxt, sel_idx;
   logic [N-1:0]  gnt_nxt, ack_nxt;
   logic          sel_valid;
   logic [K-1:0]  d;
   logic [K-1:0]  wd [N];

   for (genvar g = 0; g < N; g++) begin : g_wd
      assign wd[g] = wdata[g*K +: K];
   end

   rr_selector #(.N(N), .IW(IW)) u_sel (
      .req   (req),
      .ptr   (ptr),
      .valid (sel_valid),
      .idx   (sel_idx)
   );

   // Bank has no enable: recirculate Q except during the committing cycle.
   assign d = (state == GRANT) ? wd[gnt_idx] : Q;

   BancoRegistros #(.k(K)) u_banco (
      .CLK   (CLK),
      .Reset (Reset),
      .D     (d),
      .Q     (Q)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         gnt     <= '0;
         ack     <= '0;
         gnt_idx <= '0;
         ptr     <= '0;
      end else begin
         state   <= state_nxt;
         gnt     <= gnt_nxt;
         ack     <= ack_nxt;
         gnt_idx <= idx_nxt;
         ptr     <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sel_valid) state_nxt = GRANT;
         GRANT:   state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt = gnt;
      ack_nxt = '0;
      idx_nxt = gnt_idx;
      ptr_nxt = ptr;
      case (state)
         IDLE: if (sel_valid) begin
            gnt_nxt          = '0;
            gnt_nxt[sel_idx] = 1'b1;
            idx_nxt          = sel_idx;
            ptr_nxt          = (sel_idx == IW'(N-1)) ? '0 : sel_idx + IW'(1);
         end
         GRANT:   ack_nxt = gnt;
         ACK:     gnt_nxt = '0;
         default: gnt_nxt = '0;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_arbitro_banco_rr.sv
// Self-checking bench for arbitro_banco_rr (N=4, K=12).
module tb_arbitro_banco_rr;

   localparam int N = 4;
   localparam int K = 12;

   logic           CLK = 1'b0;
   logic           Reset;
   logic [N-1:0]   req;
   logic [N*K-1:0] wdata;
   logic [N-1:0]   gnt, ack;
   logic [1:0]     gnt_idx;
   logic           busy;
   logic [K-1:0]   Q;

   arbitro_banco_rr #(.N(N), .K(K)) dut (
      .CLK(CLK), .Reset(Reset), .req(req), .wdata(wdata),
      .gnt(gnt), .ack(ack), .gnt_idx(gnt_idx), .busy(busy), .Q(Q)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [N-1:0] req;
      logic [K-1:0] w0;
      int           idx;
      logic [K-1:0] q;
   } vec_t;

   typedef struct {
      int           idx;
      logic [K-1:0] q;
   } exp_t;

   exp_t sb[$];
   vec_t vt[10];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // One full IDLE->GRANT->ACK->IDLE transaction; req already driven.
   task automatic txn(input string nm, input int e, input logic [K-1:0] q, input bit drop);
      exp_t x;
      tick();
      chk({nm, " gnt"}, 32'(gnt), 32'(oh(e)));
      chk({nm, " gnt_idx"}, 32'(gnt_idx), 32'(e));
      chk({nm, " busy"}, 32'(busy), 32'd1);
      chk({nm, " ack_early"}, 32'(ack), 32'd0);
      sb.push_back('{idx: e, q: q});
      if (drop) req = '0;
      tick();
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL %s scoreboard: got empty expected entry", nm);
      end else begin
         x = sb.pop_front();
         chk({nm, " ack"}, 32'(ack), 32'(oh(x.idx)));
         chk({nm, " Q"}, 32'(Q), 32'(x.q));
         chk({nm, " gnt_hold"}, 32'(gnt), 32'(oh(x.idx)));
      end
      tick();
      chk({nm, " busy_end"}, 32'(busy), 32'd0);
      chk({nm, " gnt_end"}, 32'(gnt), 32'd0);
      chk({nm, " ack_end"}, 32'(ack), 32'd0);
      chk({nm, " Q_hold"}, 32'(Q), 32'(q));
   endtask

   initial begin
      Reset = 1'b1;
      req   = '0;
      for (int i = 0; i < N; i++) wdata[i*K +: K] = K'(12'h100 + i);

      // Reset held 3 cycles.
      repeat (3) tick();
      chk("rst Q", 32'(Q), 32'h000);
      chk("rst gnt", 32'(gnt), 32'd0);
      chk("rst ack", 32'(ack), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst gnt_idx", 32'(gnt_idx), 32'd0);
      Reset = 1'b0;
      repeat (2) tick();
      chk("idle Q", 32'(Q), 32'h000);
      chk("idle busy", 32'(busy), 32'd0);

      vt[0] = '{4'b1111, 12'h100, 0, 12'h100};
      vt[1] = '{4'b1111, 12'h100, 1, 12'h101};
      vt[2] = '{4'b1111, 12'h100, 2, 12'h102};
      vt[3] = '{4'b1111, 12'h100, 3, 12'h103};
      vt[4] = '{4'b1111, 12'h100, 0, 12'h100};
      vt[5] = '{4'b0001, 12'hA5C, 0, 12'hA5C};
      vt[6] = '{4'b0100, 12'hA5C, 2, 12'h102};
      vt[7] = '{4'b1001, 12'h100, 3, 12'h103};
      vt[8] = '{4'b1001, 12'h100, 0, 12'h100};
      vt[9] = '{4'b0110, 12'h100, 1, 12'h101};

      for (int v = 0; v < 10; v++) begin
         req = vt[v].req;
         wdata[0 +: K] = vt[v].w0;
         txn($sformatf("vec%0d", v), vt[v].idx, vt[v].q, 1'b0);
      end

      // ptr now 2: req0 pulsed for one cycle, dropped during GRANT.
      wdata[0 +: K] = 12'h3C3;
      req = 4'b0001;
      txn("pulse", 0, 12'h3C3, 1'b1);
      tick();
      chk("pulse ack_once", 32'(ack), 32'd0);
      chk("pulse idle", 32'(busy), 32'd0);

      // Requests arriving mid-transaction are not queued.
      req = 4'b0100;
      wdata[2*K +: K] = 12'h222;
      tick();
      req = 4'b0010;
      wdata[1*K +: K] = 12'h111;
      tick();
      chk("late req ack", 32'(ack), 32'(4'b0100));
      chk("late req Q", 32'(Q), 32'h222);
      req = '0;
      tick();
      tick();
      chk("late req dropped", 32'(busy), 32'd0);
      chk("late req Q hold", 32'(Q), 32'h222);

      // Async reset in the middle of GRANT.
      for (int i = 0; i < N; i++) wdata[i*K +: K] = 12'hFFF;
      req = 4'b0100;
      tick();
      chk("midrst gnt", 32'(gnt), 32'(4'b0100));
      req = '0;
      #2 Reset = 1'b1;
      #1;
      chk("midrst Q", 32'(Q), 32'h000);
      chk("midrst gnt0", 32'(gnt), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      tick();
      chk("midrst ack", 32'(ack), 32'd0);
      chk("midrst Q hold", 32'(Q), 32'h000);
      Reset = 1'b0;
      wdata[1*K +: K] = 12'h1E1;
      req = 4'b1010;
      txn("post rst", 1, 12'h1E1, 1'b0);
      req = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
